// File: rtl/aes_pkg.sv
// Shared AES inverse-cipher definitions: widths, FSM states, GF(2^8) helpers
// and column extract/insert using MSB-first byte order.
package aes_pkg;

  localparam int STATE_W = 128;
  localparam int COL_W   = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Multiply by x in GF(2^8) modulo 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Only the InvMixColumns constants are needed, so they are built from x2/x4/x8.
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [7:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (c)
      8'h09:   return x8 ^ b;
      8'h0b:   return x8 ^ x2 ^ b;
      8'h0d:   return x8 ^ x4 ^ b;
      8'h0e:   return x8 ^ x4 ^ x2;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [COL_W-1:0] get_col(input logic [STATE_W-1:0] s,
                                              input logic [1:0] c);
    return s[STATE_W-1-COL_W*int'(c) -: COL_W];
  endfunction

  function automatic logic [STATE_W-1:0] set_col(input logic [STATE_W-1:0] s,
                                                input logic [1:0] c,
                                                input logic [COL_W-1:0] v);
    logic [STATE_W-1:0] r;
    r = s;
    r[STATE_W-1-COL_W*int'(c) -: COL_W] = v;
    return r;
  endfunction

endpackage

// File: rtl/inv_mix_columns_seq_if.sv
// Block-level handshake bundle for the AddRoundKey + InvMixColumns stage.
interface inv_mix_columns_seq_if;
  import aes_pkg::*;

  // A transfer happens on a rising edge where valid and ready are both 1;
  // the sender holds valid and data stable until that edge, and the receiver
  // may raise or lower ready freely.
  logic               in_valid;
  logic               in_ready;
  logic [STATE_W-1:0] state_in;
  logic [STATE_W-1:0] round_key;
  logic               skip_mix;
  logic               out_valid;
  logic               out_ready;
  logic [STATE_W-1:0] state_out;

  modport slave (
    input  in_valid, state_in, round_key, skip_mix, out_ready,
    output in_ready, out_valid, state_out
  );

  modport master (
    output in_valid, state_in, round_key, skip_mix, out_ready,
    input  in_ready, out_valid, state_out
  );

endinterface

// File: rtl/inv_mix_column.sv
// Combinational InvMixColumns on one 32-bit column (row 0 in the MSB byte).
module inv_mix_column
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] col_in,
  output logic [COL_W-1:0] col_out
);

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] b0, b1, b2, b3;

  assign {a0, a1, a2, a3} = col_in;

  assign b0 = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
  assign b1 = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
  assign b2 = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
  assign b3 = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);

  assign col_out = {b0, b1, b2, b3};

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Column-serial AddRoundKey + InvMixColumns: one shared column multiplier,
// one block in flight, skip_mix bypasses the mix for the final round.
module inv_mix_columns_seq
  import aes_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  inv_mix_columns_seq_if.slave  bus,
  output state_t                dbg_state
);

  state_t             state_q, state_d;
  logic [STATE_W-1:0] work_q, work_d;
  logic [1:0]         col_cnt_q, col_cnt_d;
  logic               in_ready_q, in_ready_d;
  logic [COL_W-1:0]   mix_in, mix_out;

  assign mix_in = get_col(work_q, col_cnt_q);

  inv_mix_column u_mix (
    .col_in  (mix_in),
    .col_out (mix_out)
  );

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    col_cnt_d = col_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          work_d    = bus.state_in ^ bus.round_key;
          col_cnt_d = 2'd0;
          state_d   = bus.skip_mix ? ST_DONE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        work_d    = set_col(work_q, col_cnt_q, mix_out);
        col_cnt_d = col_cnt_q + 2'd1;
        if (col_cnt_q == 2'd3) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered ready: held low through reset, rises on every entry into IDLE.
  assign in_ready_d = (state_d == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      work_q     <= '0;
      col_cnt_q  <= 2'd0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      col_cnt_q  <= col_cnt_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.state_out = work_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed + random bench for inv_mix_columns_seq with an output scoreboard.
module tb_inv_mix_columns_seq;
  import aes_pkg::*;

  logic   clk;
  logic   rst_n;
  state_t dbg_state;
  int     checks = 0;
  int     errors = 0;
  logic [127:0] exp_q[$];

  inv_mix_columns_seq_if bus ();

  inv_mix_columns_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: bitwise shift-and-add GF(2^8) multiply
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input logic skip);
    logic [127:0] r;
    logic [31:0]  col;
    logic [7:0]   a0, a1, a2, a3;
    r = s;
    if (!skip) begin
      for (int c = 0; c < 4; c++) begin
        col = s[127-32*c -: 32];
        {a0, a1, a2, a3} = col;
        r[127-32*c -: 32] = {
          gm(a0, 8'h0e) ^ gm(a1, 8'h0b) ^ gm(a2, 8'h0d) ^ gm(a3, 8'h09),
          gm(a0, 8'h09) ^ gm(a1, 8'h0e) ^ gm(a2, 8'h0b) ^ gm(a3, 8'h0d),
          gm(a0, 8'h0d) ^ gm(a1, 8'h09) ^ gm(a2, 8'h0e) ^ gm(a3, 8'h0b),
          gm(a0, 8'h0b) ^ gm(a1, 8'h0d) ^ gm(a2, 8'h09) ^ gm(a3, 8'h0e)};
      end
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] s, input logic [127:0] k, input logic skip);
    int w;
    bus.in_valid  = 1'b1;
    bus.state_in  = s;
    bus.round_key = k;
    bus.skip_mix  = skip;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      tick();
      w++;
    end
    check("in_ready_wait", {127'd0, bus.in_ready}, 128'd1);
    exp_q.push_back(model(s ^ k, skip));
    tick();
    bus.in_valid  = 1'b0;
    bus.state_in  = rnd128();
    bus.round_key = rnd128();
    bus.skip_mix  = $urandom_range(0, 1);
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic receive();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("post_hs_out_valid", {127'd0, bus.out_valid}, 128'd0);
    check("post_hs_in_ready", {127'd0, bus.in_ready}, 128'd1);
  endtask

  // scoreboard: compare at the negedge before each output handshake edge
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL sb_unexpected: observed output %h expected none", bus.state_out);
      end
      if (exp_q.size() > 0) check("sb_data", bus.state_out, exp_q.pop_front());
    end
  end

  initial begin
    int n;
    logic [127:0] s, k, e;
    logic skip;

    bus.in_valid  = 1'b0;
    bus.state_in  = '0;
    bus.round_key = '0;
    bus.skip_mix  = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();

    // reset state
    check("rst_in_ready", {127'd0, bus.in_ready}, 128'd0);
    check("rst_out_valid", {127'd0, bus.out_valid}, 128'd0);
    check("rst_state_out", bus.state_out, 128'd0);
    check("rst_fsm", {126'd0, dbg_state}, 128'd0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready_low", {127'd0, bus.in_ready}, 128'd0);
    tick();
    check("rel_in_ready_high", {127'd0, bus.in_ready}, 128'd1);

    // mix, zero key: columns update over four edges after the accepting edge
    send(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 128'd0, 1'b0);
    check("mix_in_ready_busy", {127'd0, bus.in_ready}, 128'd0);
    wait_out(n);
    check("mix_latency", 128'(n), 128'd4);
    check("mix_vector", bus.state_out, 128'hdb135345_f20a225c_01010101_c6c6c6c6);
    receive();

    // skip mix: done right after the accepting edge
    send({16{8'hff}}, {16{8'h0f}}, 1'b1);
    wait_out(n);
    check("skip_latency", 128'(n), 128'd0);
    check("skip_in_ready", {127'd0, bus.in_ready}, 128'd0);
    check("skip_vector", bus.state_out, {16{8'hf0}});
    receive();

    // key cancels the state
    send(128'h0123456789abcdef_fedcba9876543210, 128'h0123456789abcdef_fedcba9876543210, 1'b0);
    wait_out(n);
    check("cancel_vector", bus.state_out, 128'd0);
    receive();

    // backpressure with new input traffic during DONE
    s = rnd128();
    k = rnd128();
    e = model(s ^ k, 1'b0);
    send(s, k, 1'b0);
    wait_out(n);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid  = i[0];
      bus.state_in  = rnd128();
      bus.round_key = rnd128();
      bus.skip_mix  = $urandom_range(0, 1);
      tick();
      check("bp_state_out", bus.state_out, e);
      check("bp_in_ready", {127'd0, bus.in_ready}, 128'd0);
    end
    bus.in_valid = 1'b0;
    receive();
    repeat (8) tick();
    check("bp_no_extra_accept", {127'd0, bus.out_valid}, 128'd0);

    // random blocks, back to back
    for (int i = 0; i < 8; i++) begin
      skip = $urandom_range(0, 1);
      send(rnd128(), rnd128(), skip);
      wait_out(n);
      check("rand_latency", 128'(n), skip ? 128'd0 : 128'd4);
      receive();
    end

    // reset after the second column update
    send(rnd128(), rnd128(), 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {127'd0, bus.out_valid}, 128'd0);
    check("mid_rst_in_ready", {127'd0, bus.in_ready}, 128'd0);
    check("mid_rst_work", bus.state_out, 128'd0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    #1;
    check("mid_rel_in_ready_low", {127'd0, bus.in_ready}, 128'd0);
    tick();
    check("mid_rel_in_ready_high", {127'd0, bus.in_ready}, 128'd1);
    bus.out_ready = 1'b1;
    repeat (10) tick();
    bus.out_ready = 1'b0;
    check("mid_rel_no_output", {127'd0, bus.out_valid}, 128'd0);

    // recovery block
    send(rnd128(), rnd128(), 1'b0);
    wait_out(n);
    check("recover_latency", 128'(n), 128'd4);
    receive();

    repeat (2) tick();
    check("sb_drained", 128'(exp_q.size()), 128'd0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
